// File: rtl/dsc_pkg.sv
// Shared types and constants for the dsc_mul scheduler slice.
package dsc_pkg;

  localparam int unsigned DSC_NUM_BITS = 10;
  localparam int unsigned NUM_INPUTS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    RESP
  } state_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsc_mul_sched_if.sv
// Requester/response bus between the requesters and dsc_mul_sched.
interface dsc_mul_sched_if #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_BITS = dsc_pkg::DSC_NUM_BITS,
  parameter int unsigned CYC_W    = 48
) ();

  localparam int unsigned IDW = dsc_pkg::id_w(NUM_REQ);
  localparam int unsigned ZW  = dsc_pkg::NUM_INPUTS * NUM_BITS;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*ZW-1:0] req_opnd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ZW-1:0]         rsp_z;
  logic [CYC_W-1:0]      rsp_cycles;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_opnd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err
  );

  modport master (
    output req_valid, req_opnd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_cycles, rsp_err
  );

endinterface

// File: rtl/dsc_rr_arb.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo NUM_REQ.
module dsc_rr_arb
  import dsc_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NUM_REQ);
      if (advance && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dsc_mul_sched.sv
// Job sequencer and round-robin front end for a shared 4-input dsc_mul engine.
// Optional watchdog enabled by defining DSC_MUL_SCHED_TIMEOUT_EN.
module dsc_mul_sched
  import dsc_pkg::*;
#(
  parameter  int unsigned NUM_BITS    = DSC_NUM_BITS,
  parameter  int unsigned NUM_REQ     = 2,
  parameter  int unsigned CYC_W       = 48,
  parameter  int unsigned TIMEOUT_CYC = 2**24,
  localparam int unsigned IDW         = id_w(NUM_REQ),
  localparam int unsigned ZW          = NUM_INPUTS * NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  dsc_mul_sched_if.slave      bus,
  output logic                busy,
  output logic                mul_rst,
  output logic                mul_en,
  output logic [NUM_BITS-1:0] mul_a,
  output logic [NUM_BITS-1:0] mul_b,
  output logic [NUM_BITS-1:0] mul_c,
  output logic [NUM_BITS-1:0] mul_d,
  input  logic [ZW-1:0]       mul_z,
  input  logic                mul_ov
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("dsc_mul_sched: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [ZW-1:0]    opnd_q, opnd_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [ZW-1:0]    z_q, z_d;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  logic               advance;

`ifdef DSC_MUL_SCHED_TIMEOUT_EN
  logic err_q, err_d;
`endif

  // Grants are suppressed while rst is high so req_ready honours its reset value.
  assign advance = (state_q == IDLE) && !rst;

  dsc_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .advance (advance),
    .grant   (grant),
    .idx     (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    z_d     = z_q;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
    err_d   = err_q;
`endif
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          opnd_d  = bus.req_opnd[gnt_idx*ZW +: ZW];
          id_d    = gnt_idx;
          ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (mul_ov) begin
          state_d = SETTLE;
        end
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
        else if (cnt_q == CYC_W'(TIMEOUT_CYC - 1)) begin
          state_d = RESP;
          z_d     = '0;
          cyc_d   = CYC_W'(TIMEOUT_CYC);
          err_d   = 1'b1;
        end
`endif
      end
      SETTLE: begin
        // Report the count including this final SETTLE cycle.
        cnt_d   = cnt_inc;
        cyc_d   = cnt_inc;
        z_d     = mul_z;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      z_q     <= '0;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      z_q     <= z_d;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_cycles = cyc_q;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
  assign bus.rsp_err    = err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign mul_rst = rst || (state_q == CLEAR);
  assign mul_en  = (state_q == RUN) || (state_q == SETTLE);
  assign {mul_d, mul_c, mul_b, mul_a} = opnd_q;

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Scoreboard bench for dsc_mul_sched with a latency-programmable engine stub.
module tb_dsc_mul_sched;

  localparam int unsigned NB = 10;
  localparam int unsigned NR = 2;
  localparam int unsigned CW = 48;
  localparam int unsigned ZW = 4 * NB;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1 << 24;
`endif

  typedef struct packed {
    logic [0:0]    id;
    logic [ZW-1:0] z;
    logic [CW-1:0] cyc;
    logic          err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, mul_rst, mul_en;
  logic [NB-1:0] mul_a, mul_b, mul_c, mul_d;
  logic [ZW-1:0] mul_z = '0;
  logic          mul_ov = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  rsp_t q[$];
  rsp_t exp_r, got;

  dsc_mul_sched_if #(.NUM_REQ(NR), .NUM_BITS(NB), .CYC_W(CW)) bus ();

  dsc_mul_sched #(
    .NUM_BITS    (NB),
    .NUM_REQ     (NR),
    .CYC_W       (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .mul_rst (mul_rst),
    .mul_en  (mul_en),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_c   (mul_c),
    .mul_d   (mul_d),
    .mul_z   (mul_z),
    .mul_ov  (mul_ov)
  );

  always #5 clk = ~clk;

  // Engine stub: ov rises eng_lat cycles after en rises, sticky until cleared.
  int unsigned eng_lat  = 3;
  bit          eng_hang = 1'b0;
  int unsigned eng_cnt  = 0;
  always @(posedge clk) begin
    if (mul_rst) begin
      eng_cnt <= 0;
      mul_ov  <= 1'b0;
      mul_z   <= '0;
    end else if (mul_en) begin
      eng_cnt <= eng_cnt + 1;
      if (!eng_hang && eng_cnt + 1 >= eng_lat) mul_ov <= 1'b1;
      mul_z <= ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c) * ZW'(mul_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rid, input logic [NB-1:0] a, b, c, d);
    bus.req_opnd[rid*ZW +: ZW] = {d, c, b, a};
  endtask

  task automatic submit(input int rid, output bit ok);
    ok = 1'b0;
    bus.req_valid[rid] = 1'b1;
    #1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.req_ready[rid]) ok = 1'b1;
      else tick();
    end
    if (ok) tick();
    bus.req_valid[rid] = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit && !ok) begin
      tick();
      cyc++;
      ok = bus.rsp_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    bus.req_opnd  = '0;
    tick();
    tick();
    n_checks++;
    if ({bus.req_ready, busy, bus.rsp_valid, mul_rst, mul_en, bus.rsp_err} !== 7'b0000100) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b busy=%b vld=%b mrst=%b men=%b err=%b want rdy=00 busy=0 vld=0 mrst=1 men=0 err=0",
               bus.req_ready, busy, bus.rsp_valid, mul_rst, mul_en, bus.rsp_err);
    end
    n_checks++;
    if ({mul_d, mul_c, mul_b, mul_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_opnd got %h want 0", {mul_d, mul_c, mul_b, mul_a});
    end
    n_checks++;
    if ({bus.rsp_id, bus.rsp_z, bus.rsp_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got id=%0d z=%0d cyc=%0d want 0", bus.rsp_id, bus.rsp_z, bus.rsp_cycles);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (mul_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_mul_rst got %b want 0", mul_rst);
    end
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    eng_lat = 3;
    drive(0, 10'd3, 10'd5, 10'd7, 10'd2);
    submit(0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept got none want grant"); end
    q.push_back('{1'b0, ZW'(210), CW'(eng_lat + 2), 1'b0});
    wait_rsp(40, cyc, ok);
    n_checks++;
    if (!ok || cyc != int'(eng_lat) + 3) begin
      n_fail++;
      $display("FAIL single_latency got ok=%0b cyc=%0d want cyc=%0d", ok, cyc, eng_lat + 3);
    end
    exp_r = q.pop_front();
    got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
    n_checks++;
    if (got !== exp_r) begin
      n_fail++;
      $display("FAIL single_rsp got id=%0d z=%0d cyc=%0d err=%0b want id=%0d z=%0d cyc=%0d err=%0b",
               got.id, got.z, got.cyc, got.err, exp_r.id, exp_r.z, exp_r.cyc, exp_r.err);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done got vld=%b busy=%b want 0 0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_contention();
    int seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    drive(0, 10'd2, 10'd2, 10'd2, 10'd2);
    drive(1, 10'd1, 10'd3, 10'd1, 10'd3);
    for (int i = 0; i < 4; i++)
      q.push_back('{i[0], (i % 2 == 0) ? ZW'(16) : ZW'(9), CW'(eng_lat + 2), 1'b0});
    bus.req_valid = '1;
    #1;
    for (int c = 0; c < 200 && seen < 4; c++) begin
      n_checks++;
      if ($countones(bus.req_ready) > 1) begin
        n_fail++;
        $display("FAIL contention_onehot got %b want at most one bit", bus.req_ready);
      end
      if (bus.rsp_valid) begin
        exp_r = q.pop_front();
        got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
        n_checks++;
        if (got !== exp_r) begin
          n_fail++;
          $display("FAIL contention_rsp%0d got id=%0d z=%0d cyc=%0d want id=%0d z=%0d cyc=%0d",
                   seen, got.id, got.z, got.cyc, exp_r.id, exp_r.z, exp_r.cyc);
        end
        seen++;
        if (seen == 4) bus.req_valid = '0;
      end
      tick();
    end
    bus.req_valid = '0;
    n_checks++;
    if (seen != 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", seen); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    bus.rsp_ready = 1'b0;
    drive(1, 10'd5, 10'd6, 10'd7, 10'd8);
    submit(1, ok);
    q.push_back('{1'b1, ZW'(1680), CW'(eng_lat + 2), 1'b0});
    wait_rsp(40, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout got none want rsp_valid"); end
    exp_r = q.pop_front();
    drive(0, 10'd1, 10'd1, 10'd1, 10'd1);
    bus.req_valid[0] = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
      n_checks++;
      if (got !== exp_r || {bus.rsp_valid, busy, bus.req_ready} !== 4'b1100) begin
        n_fail++;
        $display("FAIL bp_stall%0d got id=%0d z=%0d cyc=%0d vld=%b busy=%b rdy=%b want id=%0d z=%0d cyc=%0d vld=1 busy=1 rdy=00",
                 c, got.id, got.z, got.cyc, bus.rsp_valid, busy, bus.req_ready, exp_r.id, exp_r.z, exp_r.cyc);
      end
      tick();
    end
    bus.req_valid[0] = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got vld=%b want 0", bus.rsp_valid); end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_single got vld=%b busy=%b want 0 0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int cyc;
    eng_lat = 20;
    drive(0, 10'd9, 10'd9, 10'd9, 10'd9);
    submit(0, ok);
    q.push_back('{1'b0, ZW'(6561), CW'(22), 1'b0});
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({mul_rst, mul_en, busy, bus.rsp_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrun_reset got mrst=%b men=%b busy=%b vld=%b want 1 0 0 0", mul_rst, mul_en, busy, bus.rsp_valid);
    end
    rst = 1'b0;
    q.delete();
    eng_lat = 3;
    drive(0, 10'd1, 10'd1, 10'd1, 10'd1);
    submit(0, ok);
    q.push_back('{1'b0, ZW'(1), CW'(eng_lat + 2), 1'b0});
    wait_rsp(40, cyc, ok);
    exp_r = q.pop_front();
    got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
    n_checks++;
    if (!ok || got !== exp_r) begin
      n_fail++;
      $display("FAIL midrun_next got ok=%0b id=%0d z=%0d cyc=%0d want id=%0d z=%0d cyc=%0d",
               ok, got.id, got.z, got.cyc, exp_r.id, exp_r.z, exp_r.cyc);
    end
    tick();
  endtask

  task automatic test_zero_operand();
    bit ok;
    int cyc;
    drive(1, 10'd0, 10'd1023, 10'd1023, 10'd1023);
    submit(1, ok);
    q.push_back('{1'b1, ZW'(0), CW'(eng_lat + 2), 1'b0});
    wait_rsp(40, cyc, ok);
    exp_r = q.pop_front();
    got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
    n_checks++;
    if (!ok || got !== exp_r) begin
      n_fail++;
      $display("FAIL zero_rsp got ok=%0b id=%0d z=%0d cyc=%0d err=%0b want id=%0d z=0 cyc=%0d err=0",
               ok, got.id, got.z, got.cyc, got.err, exp_r.id, exp_r.cyc);
    end
    tick();
  endtask

`ifdef DSC_MUL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cyc;
    eng_hang = 1'b1;
    drive(0, 10'd3, 10'd3, 10'd3, 10'd3);
    submit(0, ok);
    q.push_back('{1'b0, ZW'(0), CW'(TO), 1'b1});
    wait_rsp(60, cyc, ok);
    n_checks++;
    if (!ok || cyc != int'(TO) + 1) begin
      n_fail++;
      $display("FAIL timeout_latency got ok=%0b cyc=%0d want cyc=%0d", ok, cyc, TO + 1);
    end
    exp_r = q.pop_front();
    got = '{bus.rsp_id, bus.rsp_z, bus.rsp_cycles, bus.rsp_err};
    n_checks++;
    if (got !== exp_r || mul_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rsp got z=%0d cyc=%0d err=%0b men=%b want z=0 cyc=%0d err=1 men=0",
               got.z, got.cyc, got.err, mul_en, TO);
    end
    eng_hang = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    bus.req_opnd  = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midrun();
    test_zero_operand();
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsc_mul_sched.md
Name: dsc_mul_sched

Overview:
Sequencer and round-robin arbiter that shares one 4-input deterministic stochastic multiplier (dsc_mul) among NUM_REQ requesters.
- Accepts one 4-operand job at a time and latches the operands.
- Clears the engine, enables it and waits for its ov flag.
- Captures z one cycle later and returns product, requester id and cycle count on a valid/ready response port.
- Sits between the requesters and the dsc_mul instance; it replaces testbench-style rst/en sequencing.

Parameters:
NUM_BITS, 10, width of each operand a/b/c/d.
NUM_REQ, 2, number of requesters (2..8).
CYC_W, 48, width of the run-cycle counter in the response; saturates at all-ones.
TIMEOUT_CYC, 2**24, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  per-requester job valid.
req_ready  out  NUM_REQ  one-hot acceptance; handshake completes when valid&ready.
req_opnd  in  NUM_REQ*4*NUM_BITS  per requester {d,c,b,a}; requester i occupies slice i.
rsp_valid  out  1  response valid.
rsp_ready  in  1  response consumer ready.
rsp_id  out  clog2(NUM_REQ)  index of the requester served.
rsp_z  out  4*NUM_BITS  product a*b*c*d.
rsp_cycles  out  CYC_W  cycles spent in RUN+SETTLE.
rsp_err  out  1  timeout flag; constant 0 without the optional feature.
busy  out  1  high in any state except IDLE.
mul_rst  out  1  engine clear; equals rst OR (state==CLEAR).
mul_en  out  1  engine enable.
mul_a, mul_b, mul_c, mul_d  out  NUM_BITS each  latched operands.
mul_z  in  4*NUM_BITS  engine result.
mul_ov  in  1  engine done flag.

Behaviour:
- Reset values:
  - state IDLE; req_ready=0; rsp_valid=0; rsp_id=0; rsp_z=0; rsp_cycles=0; rsp_err=0; busy=0.
  - mul_rst=1; mul_en=0; mul_a..d=0; round-robin pointer = requester 0 has highest priority.
- IDLE:
  - If any req_valid is set, req_ready is asserted combinationally for the winner only.
  - Winner = first valid at or after pointer, wrapping modulo NUM_REQ.
  - On the accept edge: latch operands to mul_a..d, latch id, pointer <= winner+1 (wrap), go to CLEAR.
  - req_ready is never asserted outside IDLE.
- CLEAR, exactly 1 cycle: mul_rst=1, mul_en=0, counter <= 0, then go to RUN.
- RUN:
  - mul_en=1, mul_rst=0; counter increments each cycle, saturating.
  - When mul_ov=1 is sampled, go to SETTLE. The counter still increments on that edge.
- SETTLE, exactly 1 cycle:
  - mul_en stays 1; counter increments.
  - On exit: rsp_z <= mul_z, rsp_cycles <= counter, rsp_err <= 0, go to RESP.
- RESP:
  - rsp_valid=1; mul_en=0; all rsp_* held stable.
  - On rsp_valid&rsp_ready go to IDLE.
  - No job is accepted in the same cycle as the response handshake; minimum 1 idle cycle between jobs.
- Operands are held constant on mul_a..d from accept until the next accept.
- Only one job is outstanding at a time; backpressure on rsp_ready stalls all requesters.
- Latency for an engine that asserts ov N cycles after en rises: accept -> rsp_valid = N+3 cycles; rsp_cycles = N+2.
- rst asserted in any state: immediate return to reset values on the next edge; the in-flight job is dropped with no response.
- A requester that deasserts req_valid before acceptance is simply not granted; no error.

Optional Feature:
Macro DSC_MUL_SCHED_TIMEOUT_EN.
- Defined:
  - In RUN, if the counter reaches TIMEOUT_CYC-1 with no mul_ov, go directly to RESP.
  - Response fields: rsp_err=1, rsp_z=0, rsp_cycles=TIMEOUT_CYC.
  - mul_en drops on entering RESP.
- Undefined: no watchdog logic; rsp_err tied to 0; RUN waits for mul_ov indefinitely.

Decomposition:
- Package dsc_pkg:
  - NUM_BITS default and NUM_INPUTS=4.
  - State enum {IDLE, CLEAR, RUN, SETTLE, RESP}.
  - Function for the id width (clog2).
- Sub-module dsc_rr_arb holds the round-robin grant logic: parameter NUM_REQ; inputs req/ptr/advance; outputs one-hot grant and encoded index.
- FSM, latches and counter stay in dsc_mul_sched.

Test Plan:
- Single job, requester 0, a=3, b=5, c=7, d=2, with a real dsc_mul -> one rsp: rsp_id=0, rsp_z=210, rsp_err=0; rsp_cycles = engine en-to-ov cycles + 2.
- Contention: both requesters valid from the cycle after reset, operands (2,2,2,2) and (1,3,1,3), continuously re-issued -> served in order 0,1,0,1; rsp_z 16,9,16,9; req_ready always one-hot.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, busy=1, no req_ready for the 10 cycles; then a single handshake.
- Reset mid-RUN: pulse rst for 1 cycle, 5 cycles into RUN -> next cycle has mul_rst=1, mul_en=0, busy=0, rsp_valid=0; a subsequent job (1,1,1,1) returns z=1.
- Zero operand: a=0, b=1023, c=1023, d=1023 -> rsp_z=0, rsp_err=0.
- Timeout with DSC_MUL_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, stub engine holding mul_ov=0 -> rsp_valid after 16 RUN cycles, rsp_err=1, rsp_z=0, rsp_cycles=16.
